// File: rtl/rv_core_pkg.sv
// Shared core types for the register-file write-back path: data width,
// register index width and the buffered write-back entry.
package rv_core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       wd;
  } wb_entry_t;

  // One-hot mask for a register index; x0 never maps to a bit.
  function automatic logic [NUM_REGS-1:0] reg_bit(input logic [REG_ADDR_W-1:0] r);
    logic [NUM_REGS-1:0] m;
    m = '0;
    if (r != '0) m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regfile_wb_fifo.sv
// Two-entry FIFO holding MDU write-back results until a write-port slot
// is free. Push is ignored when full, pop is ignored when empty.
module regfile_wb_fifo
  import rv_core_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  wb_entry_t  mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic       push_ok;
  logic       pop_ok;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file write port between the WB stage and buffered
// MDU results, and tracks pending MDU destinations for the hazard unit.
module regfile_wb_arbiter
  import rv_core_pkg::*;
#(
  parameter int XLEN       = rv_core_pkg::XLEN,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]       pipe_wd,
  input  logic                  mdu_valid,
  output logic                  mdu_ready,
  input  logic [REG_ADDR_W-1:0] mdu_rd,
  input  logic [XLEN-1:0]       mdu_wd,
  input  logic                  issue_v,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  output logic                  busy_rs1,
  output logic                  busy_rs2,
  output logic                  busy_rd,
  output logic                  stall_req,
  output logic                  proto_err,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_a3,
  output logic [XLEN-1:0]       rf_wd3
);

  localparam logic [3:0] STARVE_TH = 4'(STARVE_MAX);

  wb_entry_t           head;
  wb_entry_t           push_entry;
  logic                full;
  logic                empty;
  logic                push;
  logic                pipe_req;
  logic                take_buf;
  logic                take_pipe;
  logic [3:0]          starve_cnt;
  logic [3:0]          starve_nxt;
  logic [NUM_REGS-1:0] sb;
  logic [NUM_REGS-1:0] sb_nxt;

  assign pipe_req   = pipe_we && (pipe_rd != '0);
  // Once stall_req is up the head must win, even if the WB stage breaks contract.
  assign take_buf   = !empty && (stall_req || !pipe_req);
  assign take_pipe  = !take_buf && pipe_req;
  assign mdu_ready  = !full;
  assign push       = mdu_valid && !full && (mdu_rd != '0);
  assign push_entry = '{rd: mdu_rd, wd: mdu_wd};

  regfile_wb_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (take_buf),
    .din   (push_entry),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_comb begin
    starve_nxt = starve_cnt;
    if (empty || take_buf) starve_nxt = 4'd0;
    else if (starve_cnt != 4'hF) starve_nxt = starve_cnt + 4'd1;
  end

  // Clear is applied before set so a fresh issue to the same rd survives the pop.
  always_comb begin
    sb_nxt = sb;
    if (take_buf) sb_nxt = sb_nxt & ~reg_bit(head.rd);
    if (issue_v)  sb_nxt = sb_nxt | reg_bit(issue_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we      <= 1'b0;
      rf_a3      <= '0;
      rf_wd3     <= '0;
      sb         <= '0;
      starve_cnt <= 4'd0;
      stall_req  <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      if (take_buf) begin
        rf_we  <= 1'b1;
        rf_a3  <= head.rd;
        rf_wd3 <= head.wd;
      end else if (take_pipe) begin
        rf_we  <= 1'b1;
        rf_a3  <= pipe_rd;
        rf_wd3 <= pipe_wd;
      end else begin
        rf_we  <= 1'b0;
        rf_a3  <= '0;
        rf_wd3 <= '0;
      end
      sb         <= sb_nxt;
      starve_cnt <= starve_nxt;
      stall_req  <= (starve_nxt >= STARVE_TH);
      if (pipe_we && stall_req) proto_err <= 1'b1;
    end
  end

  assign busy_rs1 = (rs1 != '0) && sb[rs1];
  assign busy_rs2 = (rs2 != '0) && sb[rs2];
  assign busy_rd  = (rd  != '0) && sb[rd];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized checks of the write-back arbiter against a
// queue-based reference model.
module tb_regfile_wb_arbiter;
  import rv_core_pkg::*;

  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wd;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_wd;
  logic        issue_v;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1, rs2, rd;
  logic        busy_rs1, busy_rs2, busy_rd;
  logic        stall_req, proto_err;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.XLEN(32), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_wd(mdu_wd),
    .issue_v(issue_v), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .busy_rd(busy_rd),
    .stall_req(stall_req), .proto_err(proto_err),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  int          checks = 0;
  int          errors = 0;
  ent_t        q[$];
  logic [31:0] m_sb;
  int          m_starve;
  bit          m_stall, m_proto;
  logic        m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_sb = '0; m_starve = 0; m_stall = 0; m_proto = 0;
    m_we = 0; m_a3 = '0; m_wd = '0;
  endtask

  task automatic idle();
    rst = 0; pipe_we = 0; pipe_rd = 0; pipe_wd = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_wd = 0; issue_v = 0; issue_rd = 0;
  endtask

  // Compare current outputs with the model, advance one clock, update the model.
  task automatic step();
    int   sz0;
    bit   preq, take;
    ent_t h;
    #1;
    chk("rf_we", rf_we, m_we);
    chk("rf_a3", rf_a3, m_a3);
    chk("rf_wd3", rf_wd3, m_wd);
    chk("mdu_ready", mdu_ready, q.size() < 2);
    chk("stall_req", stall_req, m_stall);
    chk("proto_err", proto_err, m_proto);
    chk("busy_rs1", busy_rs1, (rs1 != 0) && m_sb[rs1]);
    chk("busy_rs2", busy_rs2, (rs2 != 0) && m_sb[rs2]);
    chk("busy_rd", busy_rd, (rd != 0) && m_sb[rd]);
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      sz0  = q.size();
      preq = pipe_we && (pipe_rd != 0);
      take = (sz0 > 0) && (m_stall || !preq);
      if (pipe_we && m_stall) m_proto = 1;
      if (take) begin
        h = q.pop_front();
        m_we = 1; m_a3 = h.rd; m_wd = h.wd;
        m_sb[h.rd] = 1'b0;
      end else if (preq) begin
        m_we = 1; m_a3 = pipe_rd; m_wd = pipe_wd;
      end else begin
        m_we = 0; m_a3 = 0; m_wd = 0;
      end
      if (issue_v && issue_rd != 0) m_sb[issue_rd] = 1'b1;
      if (mdu_valid && sz0 < 2 && mdu_rd != 0) q.push_back('{rd: mdu_rd, wd: mdu_wd});
      if (take || sz0 == 0) m_starve = 0;
      else if (m_starve < 15) m_starve++;
      m_stall = (m_starve >= SM);
    end
  endtask

  int first_stall;
  int wr_order[$];

  initial begin
    idle();
    rs1 = 0; rs2 = 0; rd = 0;
    rst = 1;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    model_reset();
    step();

    // pipe-only writes
    pipe_we = 1; pipe_rd = 5; pipe_wd = 32'hA;
    step();
    chk("pipe_we_lit", rf_we, 1); chk("pipe_a3_lit", rf_a3, 5); chk("pipe_wd_lit", rf_wd3, 32'hA);
    pipe_rd = 0; pipe_wd = 32'h55;
    step();
    chk("pipe_rd0_drop", rf_we, 0);
    idle();

    // MDU result in an idle slot
    issue_v = 1; issue_rd = 7; rs1 = 7;
    step();
    issue_v = 0;
    chk("busy7_set", busy_rs1, 1);
    mdu_valid = 1; mdu_rd = 7; mdu_wd = 32'h28;
    step();
    mdu_valid = 0;
    chk("mdu_not_yet", rf_we, 0);
    step();
    chk("mdu_we", rf_we, 1); chk("mdu_a3", rf_a3, 7); chk("mdu_wd", rf_wd3, 32'h28);
    chk("busy7_clr", busy_rs1, 0);

    // conflict with a busy WB stage
    issue_v = 1; issue_rd = 11; step();
    issue_rd = 12; step();
    issue_v = 0; rs1 = 11; rs2 = 12;
    first_stall = -1;
    for (int i = 0; i < 30; i++) begin
      pipe_we = !m_stall; pipe_rd = 5'($urandom_range(1, 10)); pipe_wd = $urandom;
      mdu_valid = (i < 2); mdu_rd = (i == 0) ? 5'd11 : 5'd12; mdu_wd = (i == 0) ? 32'h28 : 32'h30;
      step();
      if (i == 1) chk("full_not_ready", mdu_ready, 0);
      if (stall_req && first_stall < 0) first_stall = i;
      if (rf_we && (rf_a3 == 11 || rf_a3 == 12)) wr_order.push_back(int'(rf_a3));
    end
    chk("first_stall_cycle", first_stall, 4);
    chk("mdu_wr_count", wr_order.size(), 2);
    if (wr_order.size() == 2) begin
      chk("mdu_wr_first", wr_order[0], 11);
      chk("mdu_wr_second", wr_order[1], 12);
    end
    idle();

    // scoreboard race: re-issue rd 9 as the older rd 9 result pops
    rs1 = 9;
    issue_v = 1; issue_rd = 9; step();
    issue_v = 0; mdu_valid = 1; mdu_rd = 9; mdu_wd = 32'h99; step();
    mdu_valid = 0; issue_v = 1; issue_rd = 9; step();
    issue_v = 0;
    chk("race_a3", rf_a3, 9);
    chk("race_busy9", busy_rs1, 1);
    step();

    // randomized traffic honouring the stall contract
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      pipe_we   = m_stall ? 1'b0 : 1'($urandom_range(0, 9) < 6);
      pipe_rd   = 5'($urandom_range(0, 31));
      pipe_wd   = $urandom;
      mdu_valid = 1'($urandom_range(0, 2) == 0);
      mdu_rd    = 5'($urandom_range(0, 31));
      mdu_wd    = $urandom;
      issue_v   = 1'($urandom_range(0, 1));
      issue_rd  = 5'($urandom_range(0, 31));
      rs1 = 5'($urandom_range(0, 31)); rs2 = 5'($urandom_range(0, 31)); rd = 5'($urandom_range(0, 31));
      step();
    end
    idle();
    rst = 1; step(); rst = 0;

    // protocol violation: pipe write during stall
    chk("proto_clear", proto_err, 0);
    pipe_we = 1; pipe_rd = 2; pipe_wd = 32'h1;
    mdu_valid = 1; mdu_rd = 20; mdu_wd = 32'hBEEF;
    step();
    mdu_valid = 0;
    for (int i = 0; i < 20 && !m_stall; i++) step();
    chk("proto_stall_up", stall_req, 1);
    pipe_rd = 3; pipe_wd = 32'h3333;
    step();
    chk("proto_head_a3", rf_a3, 20); chk("proto_head_wd", rf_wd3, 32'hBEEF);
    chk("proto_set", proto_err, 1);
    idle();
    step(); step(); step();
    chk("proto_sticky", proto_err, 1);

    // reset mid-operation
    issue_v = 1; issue_rd = 14; step();
    issue_rd = 15; step();
    issue_v = 0; rs1 = 14; rs2 = 15; rd = 14;
    for (int i = 0; i < 2; i++) begin
      pipe_we = 1; pipe_rd = 1; pipe_wd = i;
      mdu_valid = 1; mdu_rd = 5'(14 + i); mdu_wd = 32'h100 + i;
      step();
    end
    mdu_valid = 0;
    chk("pre_rst_full", mdu_ready, 0);
    rst = 1; step();
    idle();
    chk("rst_ready", mdu_ready, 1);
    chk("rst_busy_rs1", busy_rs1, 0);
    chk("rst_busy_rs2", busy_rs2, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_proto", proto_err, 0);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
